// File: rtl/pieo_pkg.sv
// Shared PIEO package: default geometry and types used by the tracker,
// the pre-enqueue stage and the PIEO core.
//   PIEO_ID_LOG    : log2 of the per-flow FIFO count
//   PIEO_RANK_LOG  : rank field width
//   PIEO_TIME_LOG  : eligibility time field width
//   PIEO_FIFO_NUM  : number of per-flow FIFOs
//   PIEO_CNT_WIDTH : per-FIFO packet counter width
package pieo_pkg;

   localparam int unsigned PIEO_ID_LOG    = 2;
   localparam int unsigned PIEO_RANK_LOG  = 4;
   localparam int unsigned PIEO_TIME_LOG  = 16;
   localparam int unsigned PIEO_FIFO_NUM  = 2**PIEO_ID_LOG;
   localparam int unsigned PIEO_CNT_WIDTH = 16;

   typedef logic [PIEO_ID_LOG-1:0]    fifo_id_t;
   typedef logic [PIEO_CNT_WIDTH-1:0] fifo_cnt_t;

endpackage : pieo_pkg

// File: rtl/pieo_enq_fifo_tracker_if.sv
// Handshake bundle between the FIFO tracker, the packet writers, the
// pre-enqueue stage and the PIEO dequeue path.
//   master : drives packet-write, trigger and dequeue events
//   slave  : the tracker; returns the offer and the error flag
interface pieo_enq_fifo_tracker_if
   import pieo_pkg::*;
#(
   parameter int unsigned ID_LOG = PIEO_ID_LOG
) ();

   logic              pkt_enq_valid;
   logic [ID_LOG-1:0] pkt_enq_fifo_id;
   logic              pieo_enq_trigger;
   logic              pieo_deq_valid;
   logic [ID_LOG-1:0] pieo_deq_fifo_id;
   logic              fifos_not_enq_flag;
   logic [ID_LOG-1:0] fifo_id;
   logic              tracker_err;

   modport master (
      output pkt_enq_valid, pkt_enq_fifo_id, pieo_enq_trigger,
             pieo_deq_valid, pieo_deq_fifo_id,
      input  fifos_not_enq_flag, fifo_id, tracker_err
   );

   modport slave (
      input  pkt_enq_valid, pkt_enq_fifo_id, pieo_enq_trigger,
             pieo_deq_valid, pieo_deq_fifo_id,
      output fifos_not_enq_flag, fifo_id, tracker_err
   );

endinterface : pieo_enq_fifo_tracker_if

// File: rtl/pieo_rr_arbiter.sv
// Combinational rotating-priority find-first.
//   req     : request vector, one bit per FIFO
//   ptr     : highest-priority index this cycle
//   gnt_id  : first requesting index at or after ptr (ptr when none)
//   gnt_vld : at least one request is set
module pieo_rr_arbiter
   import pieo_pkg::*;
#(
   parameter int unsigned ID_LOG = PIEO_ID_LOG
) (
   input  logic [(2**ID_LOG)-1:0] req,
   input  logic [ID_LOG-1:0]      ptr,
   output logic [ID_LOG-1:0]      gnt_id,
   output logic                   gnt_vld
);

   localparam int unsigned FIFO_NUM = 2**ID_LOG;

   logic [ID_LOG-1:0] idx;

   // Scan from the farthest offset back to ptr so the nearest request wins.
   always_comb begin
      gnt_id = ptr;
      idx    = '0;
      for (int k = int'(FIFO_NUM) - 1; k >= 0; k--) begin
         idx = ptr + ID_LOG'(k);
         if (req[idx]) gnt_id = idx;
      end
   end

   assign gnt_vld = |req;

endmodule : pieo_rr_arbiter

// File: rtl/pieo_enq_fifo_tracker.sv
// Per-flow FIFO occupancy and PIEO residency tracker. Offers one non-empty
// FIFO without a resident PIEO descriptor to the pre-enqueue stage each
// cycle, round-robin, and tracks enqueues/dequeues of those descriptors.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : packet writes, enqueue trigger and PIEO dequeue in;
//                offer (fifos_not_enq_flag, fifo_id) and tracker_err out
// Build option PIEO_TRACKER_ERR_EN: when defined, counter saturation and
// illegal dequeues set a sticky tracker_err; otherwise it is tied low.
module pieo_enq_fifo_tracker
   import pieo_pkg::*;
#(
   parameter int unsigned ID_LOG    = PIEO_ID_LOG,
   parameter int unsigned CNT_WIDTH = PIEO_CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pieo_enq_fifo_tracker_if.slave   bus
);

   localparam int unsigned FIFO_NUM = 2**ID_LOG;

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   cnt_t                cnt_q [FIFO_NUM];
   cnt_t                cnt_d [FIFO_NUM];
   logic [FIFO_NUM-1:0] in_pieo_q, in_pieo_d;
   logic [ID_LOG-1:0]   rr_ptr_q, rr_ptr_d;

   logic [FIFO_NUM-1:0] elig;
   logic [FIFO_NUM-1:0] inc_v, dec_v;
   logic [ID_LOG-1:0]   grant_id;
   logic                grant_vld;
   logic                same_id, enq_sat, enq_ok, deq_ok, trig_ok;

   // Eligible: holds packets and has no descriptor in the PIEO.
   always_comb begin
      elig = '0;
      for (int i = 0; i < int'(FIFO_NUM); i++) begin
         elig[i] = (cnt_q[i] != '0) && !in_pieo_q[i];
      end
   end

   pieo_rr_arbiter #(.ID_LOG(ID_LOG)) u_arb (
      .req     (elig),
      .ptr     (rr_ptr_q),
      .gnt_id  (grant_id),
      .gnt_vld (grant_vld)
   );

   assign bus.fifos_not_enq_flag = grant_vld;
   assign bus.fifo_id            = grant_id;

   // Event qualification. A write to a saturated counter still fits when a
   // legal dequeue on the same FIFO lands in the same cycle (net change 0).
   assign same_id = (bus.pkt_enq_fifo_id == bus.pieo_deq_fifo_id);
   assign deq_ok  = bus.pieo_deq_valid && in_pieo_q[bus.pieo_deq_fifo_id]
                    && (cnt_q[bus.pieo_deq_fifo_id] != '0);
   assign enq_sat = (cnt_q[bus.pkt_enq_fifo_id] == '1);
   assign enq_ok  = bus.pkt_enq_valid && (!enq_sat || (deq_ok && same_id));
   assign trig_ok = bus.pieo_enq_trigger && grant_vld;

   // Decode accepted events into per-FIFO strobes.
   always_comb begin
      inc_v = '0;
      dec_v = '0;
      if (enq_ok) inc_v[bus.pkt_enq_fifo_id]  = 1'b1;
      if (deq_ok) dec_v[bus.pieo_deq_fifo_id] = 1'b1;
   end

   // Next-state: counters, residency bits and round-robin pointer.
   always_comb begin
      cnt_d     = cnt_q;
      in_pieo_d = in_pieo_q;
      rr_ptr_d  = rr_ptr_q;
      for (int i = 0; i < int'(FIFO_NUM); i++) begin
         case ({inc_v[i], dec_v[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
      if (deq_ok) in_pieo_d[bus.pieo_deq_fifo_id] = 1'b0;
      // Applied after the dequeue so a trigger always marks its FIFO resident.
      if (trig_ok) begin
         in_pieo_d[grant_id] = 1'b1;
         rr_ptr_d            = grant_id + ID_LOG'(1);
      end
   end

   // Tracking state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_NUM); i++) cnt_q[i] <= '0;
         in_pieo_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         cnt_q     <= cnt_d;
         in_pieo_q <= in_pieo_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

`ifdef PIEO_TRACKER_ERR_EN
   logic tracker_err_q, tracker_err_d;

   // Sticky error on a dropped write or an ignored dequeue.
   always_comb begin
      tracker_err_d = tracker_err_q;
      if (bus.pkt_enq_valid && !enq_ok)  tracker_err_d = 1'b1;
      if (bus.pieo_deq_valid && !deq_ok) tracker_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tracker_err_q <= 1'b0;
      else        tracker_err_q <= tracker_err_d;
   end

   assign bus.tracker_err = tracker_err_q;
`else
   assign bus.tracker_err = 1'b0;
`endif

endmodule : pieo_enq_fifo_tracker

// File: tb/tb_pieo_enq_fifo_tracker.sv
// Directed bench for pieo_enq_fifo_tracker. A second instance with 2-bit
// counters exercises saturation.
module tb_pieo_enq_fifo_tracker;

`ifdef PIEO_TRACKER_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pieo_enq_fifo_tracker_if #(.ID_LOG(2)) bus ();
   pieo_enq_fifo_tracker_if #(.ID_LOG(2)) bus_s ();

   pieo_enq_fifo_tracker #(.ID_LOG(2), .CNT_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   pieo_enq_fifo_tracker #(.ID_LOG(2), .CNT_WIDTH(2)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s)
   );

   task automatic idle();
      bus.pkt_enq_valid      = 1'b0;
      bus.pkt_enq_fifo_id    = 2'd0;
      bus.pieo_enq_trigger   = 1'b0;
      bus.pieo_deq_valid     = 1'b0;
      bus.pieo_deq_fifo_id   = 2'd0;
      bus_s.pkt_enq_valid    = 1'b0;
      bus_s.pkt_enq_fifo_id  = 2'd0;
      bus_s.pieo_enq_trigger = 1'b0;
      bus_s.pieo_deq_valid   = 1'b0;
      bus_s.pieo_deq_fifo_id = 2'd0;
   endtask

   // Advance one cycle; return 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [1:0] id);
      bus.pkt_enq_valid = 1'b1; bus.pkt_enq_fifo_id = id;
      step(); idle();
   endtask

   task automatic deq(input logic [1:0] id);
      bus.pieo_deq_valid = 1'b1; bus.pieo_deq_fifo_id = id;
      step(); idle();
   endtask

   task automatic trig();
      bus.pieo_enq_trigger = 1'b1;
      step(); idle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      step(); step();
      checks++; if (bus.fifos_not_enq_flag !== 1'b0) begin errors++; $display("FAIL rst_flag got=%0b exp=0", bus.fifos_not_enq_flag); end
      checks++; if (bus.fifo_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", bus.fifo_id); end
      checks++; if (bus.tracker_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", bus.tracker_err); end
      checks++; if (bus_s.fifos_not_enq_flag !== 1'b0) begin errors++; $display("FAIL rst_s_flag got=%0b exp=0", bus_s.fifos_not_enq_flag); end
      rst_n = 1'b1;
   endtask

   task automatic test_single_enq();
      enq(2'd2);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1) begin errors++; $display("FAIL single_flag got=%0b exp=1", bus.fifos_not_enq_flag); end
      checks++; if (bus.fifo_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", bus.fifo_id); end
      trig();
      checks++; if (bus.fifos_not_enq_flag !== 1'b0) begin errors++; $display("FAIL single_excl got=%0b exp=0", bus.fifos_not_enq_flag); end
      // Nothing eligible: offer shows rr_ptr = 2+1.
      checks++; if (bus.fifo_id !== 2'd3) begin errors++; $display("FAIL single_rrptr got=%0d exp=3", bus.fifo_id); end
      deq(2'd2);
      checks++; if (bus.fifos_not_enq_flag !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", bus.fifos_not_enq_flag); end
      checks++; if (bus.tracker_err !== 1'b0) begin errors++; $display("FAIL single_err got=%0b exp=0", bus.tracker_err); end
   endtask

   task automatic test_round_robin();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      enq(2'd0); enq(2'd1); enq(2'd3);
      bus.pieo_enq_trigger = 1'b1;
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd0) begin errors++; $display("FAIL rr_0 got flag=%0b id=%0d exp flag=1 id=0", bus.fifos_not_enq_flag, bus.fifo_id); end
      step();
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd1) begin errors++; $display("FAIL rr_1 got flag=%0b id=%0d exp flag=1 id=1", bus.fifos_not_enq_flag, bus.fifo_id); end
      step();
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd3) begin errors++; $display("FAIL rr_3 got flag=%0b id=%0d exp flag=1 id=3", bus.fifos_not_enq_flag, bus.fifo_id); end
      step();
      idle();
      // Pointer wrapped to 0 after granting FIFO 3.
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.fifo_id !== 2'd0) begin errors++; $display("FAIL rr_wrap got flag=%0b id=%0d exp flag=0 id=0", bus.fifos_not_enq_flag, bus.fifo_id); end
      deq(2'd0); deq(2'd1); deq(2'd3);
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.tracker_err !== 1'b0) begin errors++; $display("FAIL rr_drain got flag=%0b err=%0b exp flag=0 err=0", bus.fifos_not_enq_flag, bus.tracker_err); end
   endtask

   task automatic test_deq_reoffer();
      enq(2'd1); enq(2'd1);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd1) begin errors++; $display("FAIL reoff_offer got flag=%0b id=%0d exp flag=1 id=1", bus.fifos_not_enq_flag, bus.fifo_id); end
      trig();
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.fifo_id !== 2'd2) begin errors++; $display("FAIL reoff_excl got flag=%0b id=%0d exp flag=0 id=2", bus.fifos_not_enq_flag, bus.fifo_id); end
      deq(2'd1);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd1) begin errors++; $display("FAIL reoff_again got flag=%0b id=%0d exp flag=1 id=1", bus.fifos_not_enq_flag, bus.fifo_id); end
      trig();
      deq(2'd1);
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.fifo_id !== 2'd2) begin errors++; $display("FAIL reoff_empty got flag=%0b id=%0d exp flag=0 id=2", bus.fifos_not_enq_flag, bus.fifo_id); end
   endtask

   task automatic test_same_cycle();
      enq(2'd0);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd0) begin errors++; $display("FAIL same_offer got flag=%0b id=%0d exp flag=1 id=0", bus.fifos_not_enq_flag, bus.fifo_id); end
      trig();
      bus.pkt_enq_valid  = 1'b1; bus.pkt_enq_fifo_id  = 2'd0;
      bus.pieo_deq_valid = 1'b1; bus.pieo_deq_fifo_id = 2'd0;
      step(); idle();
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd0) begin errors++; $display("FAIL same_net0 got flag=%0b id=%0d exp flag=1 id=0", bus.fifos_not_enq_flag, bus.fifo_id); end
      trig();
      deq(2'd0);
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.fifo_id !== 2'd1) begin errors++; $display("FAIL same_drain got flag=%0b id=%0d exp flag=0 id=1", bus.fifos_not_enq_flag, bus.fifo_id); end
      checks++; if (bus.tracker_err !== 1'b0) begin errors++; $display("FAIL same_err got=%0b exp=0", bus.tracker_err); end
   endtask

   task automatic test_errors();
      enq(2'd2);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd2) begin errors++; $display("FAIL err_offer got flag=%0b id=%0d exp flag=1 id=2", bus.fifos_not_enq_flag, bus.fifo_id); end
      // Dequeue with no resident descriptor: ignored, state unchanged.
      deq(2'd2);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd2) begin errors++; $display("FAIL err_ign got flag=%0b id=%0d exp flag=1 id=2", bus.fifos_not_enq_flag, bus.fifo_id); end
      checks++; if (bus.tracker_err !== ERR_EN) begin errors++; $display("FAIL err_deq got=%0b exp=%0b", bus.tracker_err, ERR_EN); end
      // Trigger and dequeue on the offered FIFO: trigger wins.
      bus.pieo_enq_trigger = 1'b1;
      bus.pieo_deq_valid = 1'b1; bus.pieo_deq_fifo_id = 2'd2;
      step(); idle();
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.fifo_id !== 2'd3) begin errors++; $display("FAIL err_trigdeq got flag=%0b id=%0d exp flag=0 id=3", bus.fifos_not_enq_flag, bus.fifo_id); end
      deq(2'd2);
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.tracker_err !== ERR_EN) begin errors++; $display("FAIL err_drain got flag=%0b err=%0b exp flag=0 err=%0b", bus.fifos_not_enq_flag, bus.tracker_err, ERR_EN); end

      // Saturation on the 2-bit instance: fourth write dropped, count stays 3.
      checks++; if (bus_s.tracker_err !== 1'b0) begin errors++; $display("FAIL sat_pre got=%0b exp=0", bus_s.tracker_err); end
      for (int n = 0; n < 4; n++) begin
         bus_s.pkt_enq_valid = 1'b1; bus_s.pkt_enq_fifo_id = 2'd1;
         step(); idle();
      end
      checks++; if (bus_s.fifos_not_enq_flag !== 1'b1 || bus_s.fifo_id !== 2'd1) begin errors++; $display("FAIL sat_offer got flag=%0b id=%0d exp flag=1 id=1", bus_s.fifos_not_enq_flag, bus_s.fifo_id); end
      checks++; if (bus_s.tracker_err !== ERR_EN) begin errors++; $display("FAIL sat_err got=%0b exp=%0b", bus_s.tracker_err, ERR_EN); end
      for (int n = 2; n >= 0; n--) begin
         bus_s.pieo_enq_trigger = 1'b1;
         step(); idle();
         bus_s.pieo_deq_valid = 1'b1; bus_s.pieo_deq_fifo_id = 2'd1;
         step(); idle();
         checks++;
         if (bus_s.fifos_not_enq_flag !== (n != 0)) begin
            errors++; $display("FAIL sat_drain%0d got=%0b exp=%0b", n, bus_s.fifos_not_enq_flag, (n != 0));
         end
      end
   endtask

   task automatic test_reset_mid();
      enq(2'd0); enq(2'd1); enq(2'd2); enq(2'd3);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd3) begin errors++; $display("FAIL mid_offer got flag=%0b id=%0d exp flag=1 id=3", bus.fifos_not_enq_flag, bus.fifo_id); end
      checks++; if (bus.tracker_err !== ERR_EN) begin errors++; $display("FAIL mid_sticky got=%0b exp=%0b", bus.tracker_err, ERR_EN); end
      bus.pieo_enq_trigger = 1'b1;
      bus.pkt_enq_valid = 1'b1; bus.pkt_enq_fifo_id = 2'd0;
      step();
      // Asynchronous reset between edges, traffic still active.
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.fifos_not_enq_flag !== 1'b0 || bus.fifo_id !== 2'd0) begin errors++; $display("FAIL mid_rst got flag=%0b id=%0d exp flag=0 id=0", bus.fifos_not_enq_flag, bus.fifo_id); end
      checks++; if (bus.tracker_err !== 1'b0 || bus_s.tracker_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got=%0b/%0b exp=0/0", bus.tracker_err, bus_s.tracker_err); end
      idle();
      step();
      rst_n = 1'b1;
      step();
      checks++; if (bus.fifos_not_enq_flag !== 1'b0) begin errors++; $display("FAIL mid_cleared got=%0b exp=0", bus.fifos_not_enq_flag); end
      enq(2'd2);
      checks++; if (bus.fifos_not_enq_flag !== 1'b1 || bus.fifo_id !== 2'd2) begin errors++; $display("FAIL mid_resume got flag=%0b id=%0d exp flag=1 id=2", bus.fifos_not_enq_flag, bus.fifo_id); end
   endtask

   initial begin
      test_reset();
      test_single_enq();
      test_round_robin();
      test_deq_reoffer();
      test_same_cycle();
      test_errors();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pieo_enq_fifo_tracker
